regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports (E over D), N combinational
// read ports, optional write bypass / hardwired zero register, and a busy scoreboard.
module regfile_mp #(
    parameter int DATA_BITS  = 32,
    parameter int ADDR_BITS  = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             DWriteEnable,
    input  logic [ADDR_BITS-1:0]             DAddress,
    input  logic [DATA_BITS-1:0]             DData,
    input  logic                             EWriteEnable,
    input  logic [ADDR_BITS-1:0]             EAddress,
    input  logic [DATA_BITS-1:0]             EData,
    input  logic                             IssueEnable,
    input  logic [ADDR_BITS-1:0]             IssueAddress,
    input  logic [READ_PORTS*ADDR_BITS-1:0]  RAddress,
    output logic [READ_PORTS*DATA_BITS-1:0]  RData,
    output logic [READ_PORTS-1:0]            RBusy,
    output logic [ADDR_BITS:0]               BusyCount
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] regs [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_next;
    logic [ADDR_BITS:0]   busy_count;
    logic [ADDR_BITS:0]   count_next;
    logic                 d_ok;
    logic                 e_ok;
    logic                 i_ok;
    logic                 inc;
    logic                 dec_d;
    logic                 dec_e;

    // d_ok is dropped when E hits the same address, so each address is written
    // (and its busy bit cleared) by at most one port.
    always_comb begin
        e_ok = EWriteEnable && !(ZERO_REG != 0 && EAddress == '0);
        d_ok = DWriteEnable && !(ZERO_REG != 0 && DAddress == '0)
               && !(EWriteEnable && EAddress == DAddress);
        i_ok = IssueEnable && !(ZERO_REG != 0 && IssueAddress == '0);

        busy_next = busy;
        if (d_ok) busy_next[DAddress] = 1'b0;
        if (e_ok) busy_next[EAddress] = 1'b0;
        if (i_ok) busy_next[IssueAddress] = 1'b1;

        // Count only real bit transitions; an issue to the written address keeps it busy.
        inc   = i_ok && !busy[IssueAddress];
        dec_d = d_ok && busy[DAddress] && !(i_ok && IssueAddress == DAddress);
        dec_e = e_ok && busy[EAddress] && !(i_ok && IssueAddress == EAddress);
        count_next = busy_count + {{ADDR_BITS{1'b0}}, inc}
                     - {{ADDR_BITS{1'b0}}, dec_d} - {{ADDR_BITS{1'b0}}, dec_e};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (d_ok) regs[DAddress] <= DData;
            if (e_ok) regs[EAddress] <= EData;
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    // Reads are masked to zero while rst is high so no bypassed write leaks out.
    always_comb begin
        logic [ADDR_BITS-1:0] ra;
        logic [DATA_BITS-1:0] rd;
        RData = '0;
        RBusy = '0;
        ra    = '0;
        rd    = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            ra = RAddress[k*ADDR_BITS +: ADDR_BITS];
            rd = regs[ra];
            if (BYPASS != 0) begin
                if (EWriteEnable && EAddress == ra)      rd = EData;
                else if (DWriteEnable && DAddress == ra) rd = DData;
            end
            if (rst || (ZERO_REG != 0 && ra == '0)) begin
                rd       = '0;
                RBusy[k] = 1'b0;
            end else begin
                RBusy[k] = busy[ra];
            end
            RData[k*DATA_BITS +: DATA_BITS] = rd;
        end
    end

    assign BusyCount = busy_count;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus small random checks of regfile_mp; a bypassing and a
// non-bypassing instance share all inputs.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          DWriteEnable, EWriteEnable, IssueEnable;
    logic [AW-1:0] DAddress, EAddress, IssueAddress;
    logic [DW-1:0] DData, EData;
    logic [RP*AW-1:0] RAddress;
    logic [RP*DW-1:0] rdata_a, rdata_b;
    logic [RP-1:0]    rbusy_a, rbusy_b;
    logic [AW:0]      cnt_a, cnt_b;

    logic [DW-1:0] exp_q[$];
    string         tag_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model [32];
    logic [DW-1:0] r1, r2;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .rst(rst),
        .DWriteEnable(DWriteEnable), .DAddress(DAddress), .DData(DData),
        .EWriteEnable(EWriteEnable), .EAddress(EAddress), .EData(EData),
        .IssueEnable(IssueEnable), .IssueAddress(IssueAddress),
        .RAddress(RAddress), .RData(rdata_a), .RBusy(rbusy_a), .BusyCount(cnt_a)
    );

    regfile_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .DWriteEnable(DWriteEnable), .DAddress(DAddress), .DData(DData),
        .EWriteEnable(EWriteEnable), .EAddress(EAddress), .EData(EData),
        .IssueEnable(IssueEnable), .IssueAddress(IssueAddress),
        .RAddress(RAddress), .RData(rdata_b), .RBusy(rbusy_b), .BusyCount(cnt_b)
    );

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic expect_val(input string tag, input logic [DW-1:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic chk(input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty obs=%h", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic idle();
        DWriteEnable = 0; EWriteEnable = 0; IssueEnable = 0;
    endtask

    task automatic wr_d(input logic [AW-1:0] a, input logic [DW-1:0] d);
        DWriteEnable = 1; DAddress = a; DData = d;
    endtask

    task automatic wr_e(input logic [AW-1:0] a, input logic [DW-1:0] d);
        EWriteEnable = 1; EAddress = a; EData = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        IssueEnable = 1; IssueAddress = a;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RAddress = {a1, a0};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        DAddress = '0; EAddress = '0; IssueAddress = '0; DData = '0; EData = '0;
        // reset cycle with a write and an issue that must be ignored
        rst = 1;
        wr_d(5'd9, 32'hAAAA_5555);
        issue(5'd9);
        rd(5'd9, 5'd9);
        expect_val("rst_rdata", 0);
        expect_val("rst_rbusy", 0);
        settle();
        chk(rdata_a[31:0]);
        chk({30'd0, rbusy_a});
        cyc();
        rst = 0;
        idle();

        for (int a = 0; a < 32; a++) begin
            rd(a[AW-1:0], 5'(31 - a));
            expect_val("post_rst_rdata0", 0);
            expect_val("post_rst_rdata1", 0);
            expect_val("post_rst_rbusy", 0);
            expect_val("post_rst_count", 0);
            settle();
            chk(rdata_a[31:0]);
            chk(rdata_a[63:32]);
            chk({30'd0, rbusy_a});
            chk({26'd0, cnt_a});
        end

        // same-address write conflict, E wins
        wr_d(5'd5, 32'hDEAD_BEEF);
        wr_e(5'd5, 32'h1234_5678);
        rd(5'd5, 5'd5);
        expect_val("conflict_bypass_a", 32'h1234_5678);
        expect_val("conflict_nobypass_b", 0);
        settle();
        chk(rdata_a[31:0]);
        chk(rdata_b[31:0]);
        cyc();
        idle();
        expect_val("conflict_port0", 32'h1234_5678);
        expect_val("conflict_port1", 32'h1234_5678);
        expect_val("conflict_b", 32'h1234_5678);
        settle();
        chk(rdata_a[31:0]);
        chk(rdata_a[63:32]);
        chk(rdata_b[31:0]);

        // two writes to different addresses
        r1 = $urandom;
        r2 = $urandom;
        wr_d(5'd10, r1);
        wr_e(5'd11, r2);
        cyc();
        idle();
        rd(5'd10, 5'd11);
        expect_val("dual_write_d", r1);
        expect_val("dual_write_e", r2);
        settle();
        chk(rdata_a[31:0]);
        chk(rdata_a[63:32]);

        // bypass vs no bypass
        wr_d(5'd7, 32'h0000_CAFE);
        rd(5'd7, 5'd5);
        expect_val("bypass_a", 32'h0000_CAFE);
        expect_val("bypass_old_b", 0);
        expect_val("bypass_other_port", 32'h1234_5678);
        settle();
        chk(rdata_a[31:0]);
        chk(rdata_b[31:0]);
        chk(rdata_a[63:32]);
        cyc();
        idle();
        expect_val("bypass_next_a", 32'h0000_CAFE);
        expect_val("bypass_next_b", 32'h0000_CAFE);
        settle();
        chk(rdata_a[31:0]);
        chk(rdata_b[31:0]);
        wr_d(5'd7, 32'h1111_1111);
        wr_e(5'd7, 32'h2222_2222);
        expect_val("bypass_e_prec", 32'h2222_2222);
        settle();
        chk(rdata_a[31:0]);
        cyc();
        idle();

        // scoreboard on r3
        issue(5'd3);
        rd(5'd3, 5'd3);
        expect_val("issue_same_cycle_busy", 0);
        settle();
        chk({30'd0, rbusy_a});
        cyc();
        idle();
        expect_val("issue_busy", 32'd3);
        expect_val("issue_count", 1);
        settle();
        chk({30'd0, rbusy_a});
        chk({26'd0, cnt_a});
        issue(5'd3);
        wr_d(5'd3, 32'h33);
        expect_val("rbusy_not_bypassed", 32'd3);
        expect_val("issue_write_bypass", 32'h33);
        settle();
        chk({30'd0, rbusy_a});
        chk(rdata_a[31:0]);
        cyc();
        idle();
        expect_val("issue_write_busy", 32'd3);
        expect_val("issue_write_count", 1);
        expect_val("issue_write_data", 32'h33);
        expect_val("issue_write_data_b", 32'h33);
        settle();
        chk({30'd0, rbusy_a});
        chk({26'd0, cnt_a});
        chk(rdata_a[31:0]);
        chk(rdata_b[31:0]);
        wr_e(5'd3, 32'h44);
        cyc();
        idle();
        expect_val("clear_busy", 0);
        expect_val("clear_count", 0);
        expect_val("clear_data", 32'h44);
        settle();
        chk({30'd0, rbusy_a});
        chk({26'd0, cnt_a});
        chk(rdata_a[31:0]);

        // zero register
        wr_d(5'd0, 32'hFFFF);
        issue(5'd0);
        rd(5'd0, 5'd0);
        expect_val("zero_bypass", 0);
        settle();
        chk(rdata_a[31:0]);
        cyc();
        idle();
        expect_val("zero_rdata", 0);
        expect_val("zero_rbusy", 0);
        expect_val("zero_count", 0);
        expect_val("zero_rdata_b", 0);
        settle();
        chk(rdata_a[31:0]);
        chk({30'd0, rbusy_a});
        chk({26'd0, cnt_a});
        chk(rdata_b[31:0]);

        // busy counter netting
        issue(5'd1); cyc();
        issue(5'd2); cyc();
        issue(5'd4); cyc();
        idle();
        expect_val("count_three", 3);
        settle();
        chk({26'd0, cnt_a});
        issue(5'd1);
        cyc();
        idle();
        expect_val("reissue_no_double", 3);
        settle();
        chk({26'd0, cnt_a});
        wr_d(5'd2, 32'h2);
        issue(5'd6);
        cyc();
        idle();
        rd(5'd2, 5'd6);
        expect_val("set_clear_net", 3);
        expect_val("set_clear_rbusy", 32'd2);
        settle();
        chk({26'd0, cnt_a});
        chk({30'd0, rbusy_a});
        wr_d(5'd1, 32'h1);
        wr_e(5'd4, 32'h4);
        cyc();
        idle();
        expect_val("double_clear", 1);
        settle();
        chk({26'd0, cnt_a});

        // reset mid-operation
        wr_d(5'd9, 32'h99);
        cyc();
        idle();
        issue(5'd1); cyc();
        issue(5'd2); cyc();
        issue(5'd4); cyc();
        idle();
        expect_val("pre_rst_count", 4);
        settle();
        chk({26'd0, cnt_a});
        rst = 1;
        wr_d(5'd9, 32'h1234);
        issue(5'd5);
        rd(5'd9, 5'd1);
        expect_val("in_rst_rdata", 0);
        expect_val("in_rst_rbusy", 0);
        settle();
        chk(rdata_a[31:0]);
        chk({30'd0, rbusy_a});
        cyc();
        rst = 0;
        idle();
        expect_val("after_rst_count", 0);
        expect_val("after_rst_rbusy", 0);
        expect_val("after_rst_r9", 0);
        expect_val("after_rst_r9_b", 0);
        settle();
        chk({26'd0, cnt_a});
        chk({30'd0, rbusy_a});
        chk(rdata_a[31:0]);
        chk(rdata_b[31:0]);
        rd(5'd2, 5'd4);
        expect_val("after_rst_rbusy24", 0);
        settle();
        chk({30'd0, rbusy_a});

        // random writes against a reference array
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] da, ea;
            logic [DW-1:0] dd, ed;
            logic de, ee;
            da = AW'($urandom_range(0, 31));
            ea = AW'($urandom_range(0, 31));
            if (i % 6 == 0) ea = da;
            dd = $urandom;
            ed = $urandom;
            de = 1'($urandom_range(0, 1));
            ee = 1'($urandom_range(0, 1));
            if (de && da != 0) model[da] = dd;
            if (ee && ea != 0) model[ea] = ed;
            if (de) wr_d(da, dd);
            if (ee) wr_e(ea, ed);
            cyc();
            idle();
            rd(da, ea);
            expect_val("rand_port0", model[da]);
            expect_val("rand_port1", model[ea]);
            expect_val("rand_b_port0", model[da]);
            settle();
            chk(rdata_a[31:0]);
            chk(rdata_a[63:32]);
            chk(rdata_b[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
